// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared fetch-path constants and the fetch FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with flush; head word is read straight from
//            the storage registers.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign data  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch with one outstanding memory request, a small
//            prefetch buffer and redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_en,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [XLEN-1:0]        instr,
    output logic [XLEN-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0] count
);

    import riscv_pkg::*;

    localparam int              c_CW      = $clog2(DEPTH) + 1;
    localparam int              c_CW1     = c_CW + 1;
    localparam logic [c_CW:0]   c_DEPTH_W = c_CW1'(DEPTH);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   w_fetch_pc_next;
    logic [XLEN-1:0]   r_req_addr;
    logic [XLEN-1:0]   w_req_addr_next;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_issue;
    logic [c_CW:0]     w_count_ext;
    logic [c_CW:0]     w_count_after;
    logic              w_room_idle;
    logic              w_room_wait;
    logic [2*XLEN-1:0] w_head;

    assign instr_valid = (count != '0);
    assign w_pop       = instr_valid && instr_ready && !redirect_en;

    // Credit check: a new request is only launched when its reply is sure to fit.
    assign w_count_ext   = {1'b0, count};
    assign w_count_after = w_count_ext + c_CW1'(1) - {{c_CW{1'b0}}, w_pop};
    assign w_room_idle   = (w_count_ext < c_DEPTH_W);
    assign w_room_wait   = (w_count_after < c_DEPTH_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_req_addr <= w_req_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_req_addr_next = r_req_addr;
        w_push          = 1'b0;
        w_flush         = 1'b0;
        w_issue         = 1'b0;
        if (redirect_en) begin
            // The in-flight reply (if any) belongs to the old path and is dropped.
            w_flush         = 1'b1;
            w_fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
            if (r_state != IDLE) begin
                w_state_next = imem_ack ? IDLE : DROP;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_room_idle) begin
                        w_issue      = 1'b1;
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        w_push = 1'b1;
                        if (w_room_wait) begin
                            w_issue = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
            if (w_issue) begin
                w_req_addr_next = r_fetch_pc;
                w_fetch_pc_next = r_fetch_pc + c_PC_STEP;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   ({r_req_addr, imem_rdata}),
        .data  (w_head),
        .count (count)
    );

    assign imem_req  = (r_state != IDLE);
    assign imem_addr = r_req_addr;
    assign instr_pc  = w_head[2*XLEN-1:XLEN];
    assign instr     = w_head[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Randomized scoreboard bench for fetch_unit: the consumer must see
//            a gap-free word stream starting at each reset/redirect target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int lat_mode  = 0;
    int fixed_lat = 0;
    int cur_lat   = 0;
    int wc        = 0;

    fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        while (exp_q.size() > 0 && exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
    endtask

    // Memory model: reply latency in cycles after the request first appears.
    always begin
        @(posedge clk);
        #1;
        if (rst || !imem_req) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            wc         = 0;
        end else begin
            if (wc == 0) cur_lat = (lat_mode == 2) ? int'($urandom_range(0, 3)) : fixed_lat;
            if (wc >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wc         = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wc++;
            end
        end
    end

    // Monitor: pops the expected stream on every accepted instruction.
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            if (prev_pend) begin
                check("req_held", {31'd0, imem_req}, 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            check("valid_vs_count", {31'd0, instr_valid}, {31'd0, (count != 3'd0)});
            if (count > 3'(DEPTH)) check("count_le_depth", {29'd0, count}, DEPTH);
            if (!redirect_en && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, mem_word(e));
                end
            end
        end
        prev_pend = imem_req && !imem_ack && !rst;
        prev_addr = imem_addr;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 timeouts", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] a0;
        logic [2:0]  c0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        rst = 1'b0;
        restart_stream(RESET_PC);
        step();

        // Back-to-back fetch with immediate acks
        for (int i = 0; i < 4; i++) begin
            check("seq_req", {31'd0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(4 * i));
            if (i > 0) begin
                check("seq_valid", {31'd0, instr_valid}, 32'd1);
                check("seq_pc", instr_pc, 32'(4 * (i - 1)));
            end
            step();
        end

        // Decode stalled: buffer fills and fetch stops
        instr_ready = 1'b0;
        repeat (8) step();
        check("full_count", {29'd0, count}, 32'd4);
        check("full_req", {31'd0, imem_req}, 32'd0);
        instr_ready = 1'b1;
        repeat (10) step();

        // Slow memory: address held, one push per reply
        fixed_lat = 3;
        k = 0;
        while (!imem_ack && k < 20) begin step(); k++; end
        check("slow_ack_seen", {31'd0, imem_ack}, 32'd1);
        step();
        instr_ready = 1'b0;
        a0 = imem_addr;
        c0 = count;
        for (int j = 0; j < 3; j++) begin
            check("slow_addr", imem_addr, a0);
            check("slow_nopush", {29'd0, count}, {29'd0, c0});
            step();
        end
        check("slow_addr4", imem_addr, a0);
        step();
        check("slow_push", {29'd0, count}, {29'd0, c0} + 32'd1);
        instr_ready = 1'b1;
        repeat (6) step();

        // Redirect while a request is outstanding
        fixed_lat = 2;
        k = 0;
        while (!(imem_req && !imem_ack) && k < 20) begin step(); k++; end
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0103;
        restart_stream(32'h0000_0100);
        step();
        redirect_en = 1'b0;
        check("redir_count", {29'd0, count}, 32'd0);
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        k = 0;
        while (!(imem_req && imem_addr == 32'h100) && k < 20) begin step(); k++; end
        check("redir_addr", imem_addr, 32'h0000_0100);
        k = 0;
        while (!instr_valid && k < 20) begin step(); k++; end
        check("redir_pc", instr_pc, 32'h0000_0100);

        // Redirect + push + pop in the same cycle with two entries buffered
        fixed_lat = 0;
        instr_ready = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        restart_stream(32'h0000_0200);
        step();
        redirect_en = 1'b0;
        k = 0;
        while (!(count == 3'd2 && imem_ack) && k < 20) begin step(); k++; end
        check("rpp_count_pre", {29'd0, count}, 32'd2);
        instr_ready = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0300;
        restart_stream(32'h0000_0300);
        step();
        redirect_en = 1'b0;
        check("rpp_count", {29'd0, count}, 32'd0);
        check("rpp_valid", {31'd0, instr_valid}, 32'd0);

        // Address wrap at the top of the address space
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        restart_stream(32'hFFFF_FFFC);
        step();
        redirect_en = 1'b0;
        k = 0;
        while (!(imem_req && imem_addr == 32'hFFFF_FFFC) && k < 20) begin step(); k++; end
        check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        repeat (4) step();

        // Reset while waiting on memory
        fixed_lat = 3;
        k = 0;
        while (!(imem_req && !imem_ack) && k < 20) begin step(); k++; end
        rst = 1'b1;
        step();
        check("rstw_req", {31'd0, imem_req}, 32'd0);
        check("rstw_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        restart_stream(RESET_PC);
        step();
        check("rstw_req1", {31'd0, imem_req}, 32'd1);
        check("rstw_addr", imem_addr, RESET_PC);

        // Randomized traffic
        lat_mode = 2;
        for (int n = 0; n < 1500; n++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                redirect_en = 1'b1;
                redirect_pc = $urandom;
                restart_stream({redirect_pc[31:2], 2'b00});
            end else begin
                redirect_en = 1'b0;
            end
            step();
        end
        redirect_en = 1'b0;
        instr_ready = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
